// File: rtl/wb_sequencer_pkg.sv
// rtl/wb_sequencer_pkg.sv - shared widths, opcodes, c_sel encodings and FSM states
// The writeback selector mux decodes the same SEL_* values this sequencer drives.
package wb_sequencer_pkg;

   localparam int DATA_W      = 8;
   localparam int INSTR_W     = 16;
   localparam int RADDR_W     = 3;
   localparam int TIMEOUT_CYC = 16;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ALU  = 4'd1;
   localparam logic [3:0] OP_LD   = 4'd2;
   localparam logic [3:0] OP_LDI  = 4'd3;
   localparam logic [3:0] OP_LINK = 4'd4;
   localparam logic [3:0] OP_MOV  = 4'd5;
   localparam logic [3:0] OP_ST   = 4'd6;
   localparam logic [3:0] OP_HLT  = 4'd7;

   localparam logic [2:0] SEL_RESULT = 3'b000;
   localparam logic [2:0] SEL_DATAIN = 3'b001;
   localparam logic [2:0] SEL_NUM    = 3'b010;
   localparam logic [2:0] SEL_ADDR   = 3'b011;
   localparam logic [2:0] SEL_RY     = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

endpackage

// File: rtl/wb_sequencer_if.sv
// rtl/wb_sequencer_if.sv - instruction-bus and data-bus handshake bundle
// master = sequencer side, slave = memory/fetch side.
interface wb_sequencer_if;
   import wb_sequencer_pkg::*;

   logic               if_req;
   logic               if_ack;
   logic [INSTR_W-1:0] instr;
   logic               bus_req;
   logic               bus_we;
   logic               bus_ack;

   modport master (
      output if_req, bus_req, bus_we,
      input  if_ack, instr, bus_ack
   );

   modport slave (
      input  if_req, bus_req, bus_we,
      output if_ack, instr, bus_ack
   );

endinterface

// File: rtl/wb_sequencer_decode.sv
// rtl/wb_sequencer_decode.sv - wb_decode: opcode to writeback source / bus-access lookup
// Illegal opcodes fall through to the NOP row (no bus access, no writeback).
module wb_decode
   import wb_sequencer_pkg::*;
(
   input  logic [3:0] op,
   output logic [2:0] c_sel,
   output logic       needs_mem,
   output logic       is_store,
   output logic       writes_rf
);

   always_comb begin
      c_sel     = SEL_RESULT;
      needs_mem = 1'b0;
      is_store  = 1'b0;
      writes_rf = 1'b0;
      case (op)
         OP_ALU:  writes_rf = 1'b1;
         OP_LD: begin
            c_sel     = SEL_DATAIN;
            needs_mem = 1'b1;
            writes_rf = 1'b1;
         end
         OP_LDI: begin
            c_sel     = SEL_NUM;
            writes_rf = 1'b1;
         end
         OP_LINK: begin
            c_sel     = SEL_ADDR;
            writes_rf = 1'b1;
         end
         OP_MOV: begin
            c_sel     = SEL_RY;
            writes_rf = 1'b1;
         end
         OP_ST: begin
            needs_mem = 1'b1;
            is_store  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/wb_sequencer.sv
// rtl/wb_sequencer.sv - fetch/decode/exec/mem/writeback sequencer driving c_sel and rf_we
// Optional bus-wait timeout with sticky err: define WB_BUS_TIMEOUT_EN.
module wb_sequencer
   import wb_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   wb_sequencer_if.master     bus,
   output logic [2:0]         c_sel,
   output logic               rf_we,
   output logic [RADDR_W-1:0] rf_waddr,
   output logic [RADDR_W-1:0] rf_raddr_y,
   output logic               pc_inc,
   output logic               busy,
   output logic               halted,
   output logic               err
);

   state_t             state;
   state_t             state_nxt;
   logic [INSTR_W-1:0] ir;
   logic               pc_inc_q;
   logic               pc_inc_nxt;
   logic [3:0]         op;
   logic [2:0]         dec_sel;
   logic               dec_mem;
   logic               dec_store;
   logic               dec_wr;
   logic               timeout;
   logic               in_instr;
   logic               unused_ir;

   assign op        = ir[15:12];
   assign unused_ir = ^ir[5:0];

   wb_decode u_decode (
      .op        (op),
      .c_sel     (dec_sel),
      .needs_mem (dec_mem),
      .is_store  (dec_store),
      .writes_rf (dec_wr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ir       <= '0;
         pc_inc_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc_inc_q <= pc_inc_nxt;
         if (state == S_FETCH && bus.if_ack)
            ir <= bus.instr;
      end
   end

   // pc_inc_nxt covers the paths that skip WB (NOP/illegal and ST); WB raises pc_inc itself.
   always_comb begin
      state_nxt  = state;
      pc_inc_nxt = 1'b0;
      case (state)
         S_IDLE, S_HALT: begin
            if (start)
               state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (bus.if_ack)
               state_nxt = S_DECODE;
            else if (timeout)
               state_nxt = S_HALT;
         end
         S_DECODE: begin
            if (op == OP_HLT) begin
               state_nxt = S_HALT;
            end else if (dec_mem) begin
               state_nxt = S_MEM;
            end else if (!dec_wr) begin
               state_nxt  = S_FETCH;
               pc_inc_nxt = 1'b1;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: state_nxt = S_WB;
         S_MEM: begin
            if (bus.bus_ack) begin
               if (dec_store) begin
                  state_nxt  = S_FETCH;
                  pc_inc_nxt = 1'b1;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (timeout) begin
               state_nxt = S_HALT;
            end
         end
         S_WB:    state_nxt = S_FETCH;
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef WB_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state_nxt != state)
            wait_cnt <= '0;
         else if ((state == S_FETCH || state == S_MEM) && wait_cnt != CNT_W'(TIMEOUT_CYC))
            wait_cnt <= wait_cnt + 1'b1;
         if (timeout)
            err_q <= 1'b1;
      end
   end

   // wait_cnt counts cycles already spent waiting, so the last allowed cycle is TIMEOUT_CYC-1.
   assign timeout = ((state == S_FETCH && !bus.if_ack) || (state == S_MEM && !bus.bus_ack))
                    && wait_cnt == CNT_W'(TIMEOUT_CYC - 1);
   assign err     = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   assign in_instr    = state inside {S_DECODE, S_EXEC, S_MEM, S_WB};
   assign c_sel       = in_instr ? dec_sel : SEL_RESULT;
   assign rf_waddr    = in_instr ? ir[11:9] : '0;
   assign rf_raddr_y  = in_instr ? ir[8:6] : '0;
   assign rf_we       = (state == S_WB);
   assign pc_inc      = (state == S_WB) || pc_inc_q;
   assign busy        = !(state == S_IDLE || state == S_HALT);
   assign halted      = (state == S_HALT);
   assign bus.if_req  = (state == S_FETCH);
   assign bus.bus_req = (state == S_MEM);
   assign bus.bus_we  = (state == S_MEM) && dec_store;

endmodule

// File: tb/tb_wb_sequencer.sv
// tb/tb_wb_sequencer.sv - randomized scoreboard bench for wb_sequencer
module tb_wb_sequencer;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       start = 1'b0;
   logic [2:0] c_sel;
   logic       rf_we;
   logic [2:0] rf_waddr;
   logic [2:0] rf_raddr_y;
   logic       pc_inc;
   logic       busy;
   logic       halted;
   logic       err;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct {
      logic       wb;
      logic [2:0] sel;
      logic [2:0] rx;
      logic [2:0] ry;
      logic       is_mov;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   logic bus_q[$];
   exp_t me;

   wb_sequencer_if bus();

   wb_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .c_sel      (c_sel),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_raddr_y (rf_raddr_y),
      .pc_inc     (pc_inc),
      .busy       (busy),
      .halted     (halted),
      .err        (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic finish_run();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: opcode table straight from the instruction set description.
   function automatic void model(input logic [15:0] w, output logic wb, output logic [2:0] sel,
                                 output logic mem, output logic st, output logic hlt);
      wb = 0; sel = 3'd0; mem = 0; st = 0; hlt = 0;
      case (w[15:12])
         4'd1: wb = 1;
         4'd2: begin wb = 1; sel = 3'd1; mem = 1; end
         4'd3: begin wb = 1; sel = 3'd2; end
         4'd4: begin wb = 1; sel = 3'd3; end
         4'd5: begin wb = 1; sel = 3'd4; end
         4'd6: begin mem = 1; st = 1; end
         4'd7: hlt = 1;
         default: ;
      endcase
   endfunction

   task automatic check_quiet(input string tag);
      chk({tag, " c_sel"}, c_sel, 0);
      chk({tag, " rf_we"}, rf_we, 0);
      chk({tag, " rf_waddr"}, rf_waddr, 0);
      chk({tag, " pc_inc"}, pc_inc, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " halted"}, halted, 0);
      chk({tag, " if_req"}, bus.if_req, 0);
      chk({tag, " bus_req"}, bus.bus_req, 0);
   endtask

   task automatic fetch(input logic [15:0] w, input int fd, output int ac);
      int n = 0;
      while (bus.if_req !== 1'b1) begin
         if (n == 50) begin chk("if_req wait", bus.if_req, 1); finish_run(); end
         tick();
         n++;
      end
      repeat (fd) begin bus.bus_ack = 1'($urandom_range(0, 1)); tick(); end
      bus.bus_ack = 0;
      bus.instr   = w;
      bus.if_ack  = 1;
      ac = cyc;
      tick();
      bus.if_ack = 0;
      bus.instr  = 16'($urandom);
   endtask

   task automatic wait_bus_req();
      int n = 0;
      while (bus.bus_req !== 1'b1) begin
         if (n == 20) begin chk("bus_req wait", bus.bus_req, 1); finish_run(); end
         tick();
         n++;
      end
   endtask

   task automatic mem_phase(input int md);
      wait_bus_req();
      repeat (md) begin
         bus.if_ack = 1'($urandom_range(0, 1));
         start      = 1'($urandom_range(0, 1));
         tick();
      end
      bus.if_ack  = 0;
      start       = 0;
      bus.bus_ack = 1;
      tick();
      bus.bus_ack = 0;
   endtask

   task automatic run_instr(input logic [15:0] w, input int fd, input int md);
      logic wb, mem, st, hlt;
      logic [2:0] sel;
      int ac;
      exp_t e;
      model(w, wb, sel, mem, st, hlt);
      fetch(w, fd, ac);
      if (hlt) begin
         tick();
         chk("halted after HLT", halted, 1);
         chk("busy in HALT", busy, 0);
         chk("c_sel in HALT", c_sel, 0);
         start = 1; tick(); start = 0;
      end else begin
         e.wb     = wb;
         e.sel    = sel;
         e.rx     = w[11:9];
         e.ry     = w[8:6];
         e.is_mov = (w[15:12] == 4'd5);
         e.cyc    = ac + (mem ? 3 + md : (wb ? 3 : 2));
         exp_q.push_back(e);
         if (mem) begin
            bus_q.push_back(st);
            mem_phase(md);
         end
      end
   endtask

   // Scoreboard monitor: every pc_inc/rf_we pulse and every completed bus access pops one entry.
   always @(negedge clk) begin
      if (pc_inc === 1'b1 || rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious pc_inc/rf_we", {pc_inc, rf_we}, 0);
         end else begin
            me = exp_q.pop_front();
            chk("pc_inc", pc_inc, 1);
            chk("pulse cycle", cyc, me.cyc);
            chk("rf_we", rf_we, me.wb);
            if (me.wb) begin
               chk("rf_waddr", rf_waddr, me.rx);
               chk("c_sel", c_sel, me.sel);
            end
            if (me.is_mov) chk("rf_raddr_y", rf_raddr_y, me.ry);
         end
      end
      if (!rst && bus.bus_req === 1'b1 && bus.bus_ack === 1'b1) begin
         if (bus_q.size() == 0) chk("spurious bus access", bus.bus_req, 0);
         else chk("bus_we", bus.bus_we, bus_q.pop_front());
      end
   end

   initial begin
      int ac;
      bus.if_ack  = 0;
      bus.bus_ack = 0;
      bus.instr   = 16'h0;
      repeat (3) tick();
      check_quiet("reset");
      chk("reset err", err, 0);
      rst = 0;
      start = 1; tick(); start = 0;

      run_instr(16'h1A40, 0, 0);
      run_instr(16'h2C00, 0, 3);
      run_instr(16'h6000, 1, 1);
      run_instr(16'h3200, 0, 0);
      run_instr(16'h4400, 2, 0);
      run_instr(16'h5640, 0, 0);
      run_instr(16'hF000, 1, 0);
      run_instr(16'h7000, 0, 0);

      for (int i = 0; i < 60; i++)
         run_instr(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));

      // Reset lands on the same edge as bus_ack: no writeback may follow.
      fetch(16'h2C00, 0, ac);
      wait_bus_req();
      bus.bus_ack = 1;
      rst = 1;
      tick();
      bus.bus_ack = 0;
      check_quiet("rst in MEM");
      tick();
      check_quiet("after rst");
      rst = 0;

`ifdef WB_BUS_TIMEOUT_EN
      begin
         int n = 0;
         start = 1; tick(); start = 0;
         fetch(16'h2C00, 0, ac);
         wait_bus_req();
         while (bus.bus_req === 1'b1 && n < 40) begin tick(); n++; end
         chk("timeout MEM cycles", n, 16);
         chk("timeout halted", halted, 1);
         chk("timeout err", err, 1);
         start = 1; tick(); start = 0;
         tick();
         chk("err sticky after start", err, 1);
         rst = 1; tick(); rst = 0;
         chk("err cleared by rst", err, 0);
      end
`else
      chk("err tied low", err, 0);
`endif

      repeat (4) tick();
      chk("expect queue drained", exp_q.size(), 0);
      chk("bus queue drained", bus_q.size(), 0);
      finish_run();
   end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
Multi-cycle control sequencer that drives the writeback source-select mux (c_sel) and the register-file write strobe of the 8-bit datapath.
- Walks each instruction through fetch, decode, execute, an optional data-bus access, and writeback.
- Handshakes with the instruction bus and the data bus.
- Its c_sel/rf_we/rf_waddr outputs are the controlling end of the writeback path.

Parameters:
DATA_W, 8, datapath and bus data width
INSTR_W, 16, instruction word width
RADDR_W, 3, register index width (8 registers)
TIMEOUT_CYC, 16, bus-wait limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: leave IDLE/HALT and begin fetching
if_req  out  1  instruction fetch request
if_ack  in  1  instruction word valid this cycle
instr  in  INSTR_W  instruction word, sampled when if_req&&if_ack
bus_req  out  1  data-bus access request
bus_we  out  1  1=store, 0=load; valid while bus_req
bus_ack  in  1  data-bus access complete this cycle
c_sel  out  3  writeback source: 000 Result, 001 Datain_Bus, 010 num, 011 Adress_Instruction_Bus, 100 Ry
rf_we  out  1  register-file write enable, one cycle per writeback
rf_waddr  out  RADDR_W  destination register (Rx)
rf_raddr_y  out  RADDR_W  source register (Ry)
pc_inc  out  1  one-cycle program-counter increment pulse
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
err  out  1  bus timeout flag, sticky (optional feature only; else tied 0)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled at the clk rising edge.
- Reset values:
  - State goes to IDLE.
  - All outputs 0, including c_sel=000 and the instruction register.
  - rst overrides everything, including a bus access in flight. A mid-transaction rst drops bus_req/if_req on the next edge with no writeback.
- Instruction fields: op=instr[15:12], rx=instr[11:9], ry=instr[8:6]; remaining bits ignored.
- Opcodes:
  - 0 NOP: no writeback.
  - 1 ALU: c_sel 000.
  - 2 LD: bus read, then c_sel 001.
  - 3 LDI: c_sel 010.
  - 4 LINK: c_sel 011.
  - 5 MOV: c_sel 100.
  - 6 ST: bus write, no writeback.
  - 7 HLT.
  - 8–15 are illegal and treated as NOP.
- FSM states and transitions:
  - IDLE: go to FETCH on start.
  - FETCH: if_req=1 while waiting. On if_ack, latch instr into IR and go to DECODE.
  - DECODE: drive rf_raddr_y=ry. HLT → HALT; LD/ST → MEM; NOP/illegal → FETCH with pc_inc; others → EXEC.
  - EXEC: single cycle, gives the ALU/operands one cycle to settle; then WB.
  - MEM: bus_req=1, bus_we=(op==ST) until bus_ack. Then LD → WB; ST → FETCH with pc_inc.
  - WB: rf_we=1 and pc_inc=1 for exactly one cycle; then FETCH.
  - HALT: halted=1; go to FETCH on start.
- Output timing:
  - c_sel and rf_waddr hold the decoded value from DECODE through WB and are stable the whole cycle rf_we is high.
  - Outside instruction execution c_sel=000.
  - All outputs are registered (Moore); no combinational path from ack inputs to outputs.
- Latency per instruction, with immediate acks: ALU/LDI/LINK/MOV 4 cycles; LD 4; ST 3; NOP 2.
- Acks:
  - if_ack while not in FETCH is ignored; bus_ack while not in MEM is ignored.
  - if_ack together with rst: rst wins.
- start is ignored while busy.

Optional Feature:
- WB_BUS_TIMEOUT_EN defined:
  - A counter runs in FETCH and MEM, clears on state entry, and saturates.
  - Reaching TIMEOUT_CYC without an ack sets err=1 (sticky until rst), drops the request, and goes to HALT with no writeback.
- Not defined: no counter, err tied 0, waits are unbounded.

Decomposition:
- Shared package: opcode constants (OP_NOP…OP_HLT), c_sel encodings (SEL_RESULT, SEL_DATAIN, SEL_NUM, SEL_ADDR, SEL_RY), and the state enum. The selector mux and this block share the c_sel encodings.
- One natural sub-module: wb_decode, a combinational op→{c_sel, needs_mem, is_store, writes_rf} lookup.

Test Plan:
- rst, start, instr=0x1A40 (ALU rx=5) with if_ack the next cycle → rf_we pulses one cycle with rf_waddr=5, c_sel=000; pc_inc in the same cycle.
- LD instr=0x2C00, bus_ack held low 3 cycles → bus_req=1, bus_we=0 for 4 cycles; then a WB cycle with c_sel=001, rf_waddr=6.
- ST instr=0x6000 → bus_we=1 during MEM; rf_we never asserts; pc_inc on the bus_ack cycle+1.
- LDI/LINK/MOV (0x3200/0x4400/0x5640) → c_sel 010/011/100 respectively, with rf_raddr_y=1 for MOV; illegal op 0xF000 → no rf_we, pc_inc pulse only.
- rst asserted during MEM with bus_ack the same cycle → next cycle IDLE, all outputs 0, no rf_we.
- WB_BUS_TIMEOUT_EN, TIMEOUT_CYC=16, LD with no bus_ack → err=1 and halted=1 after 16 MEM cycles; err stays 1 after a subsequent start until rst.
